// File: rtl/ring_queue_pkg.sv
// Shared state encoding and width helpers for the ring_queue circular FIFO.
package ring_queue_pkg;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        PARTIAL = 2'd1,
        FULL    = 2'd2
    } state_t;

    // Pointer width for a given depth; never below 1 bit so DEPTH = 2 still has a real pointer.
    function automatic int ptr_width(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

    // Counter width must hold the value DEPTH itself.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/ring_queue_ptr.sv
// Wrapping pointer: counts 0..DEPTH-1 and returns to 0, with an explicit compare for non-power-of-two depths.
module ring_queue_ptr
    import ring_queue_pkg::*;
#(
    parameter int DEPTH = 64,
    localparam int PTR_W = ptr_width(DEPTH)
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Clear,
    input  logic             Inc,
    output logic [PTR_W-1:0] Ptr
);

    localparam logic [PTR_W-1:0] LAST = PTR_W'(DEPTH - 1);

    logic [PTR_W-1:0] ptr_q;
    logic [PTR_W-1:0] ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (Clear) begin
            ptr_d = '0;
        end else if (Inc) begin
            ptr_d = (ptr_q == LAST) ? '0 : ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign Ptr = ptr_q;

endmodule

// File: rtl/ring_queue.sv
// Circular-buffer FIFO with first-word-fall-through output, occupancy flags, flush and sticky overflow.
//   state   | meaning
//   EMPTY   | Count = 0, nothing to present
//   PARTIAL | 0 < Count < DEPTH
//   FULL    | Count = DEPTH, producer held off
module ring_queue
    import ring_queue_pkg::*;
#(
    parameter int DEPTH    = 64,
    parameter int WIDTH    = 32,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 2,
    localparam int PTR_W   = ptr_width(DEPTH),
    localparam int CNT_W   = cnt_width(DEPTH)
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Flush,
    input  logic [WIDTH-1:0] Data_In,
    input  logic             InputValid,
    output logic             InputReady,
    output logic [WIDTH-1:0] Data_Out,
    output logic             OutputValid,
    input  logic             ConsumerBusy,
    output logic [CNT_W-1:0] Count,
    output logic             AlmostFull,
    output logic             AlmostEmpty,
    output logic             Overflow,
    input  logic             ErrorClear
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];

    state_t           state_q;
    logic [CNT_W-1:0] count_q;
    logic             overflow_q;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             push;
    logic             pop;
    logic             ovf_set;

    assign InputReady  = (state_q != FULL);
    assign OutputValid = (state_q != EMPTY);
    assign push        = InputValid & InputReady;
    assign pop         = OutputValid & ~ConsumerBusy;
    assign ovf_set     = InputValid & (state_q == FULL);

    ring_queue_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
        .Clock (Clock),
        .Reset (Reset),
        .Clear (Flush),
        .Inc   (push),
        .Ptr   (wr_ptr)
    );

    ring_queue_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
        .Clock (Clock),
        .Reset (Reset),
        .Clear (Flush),
        .Inc   (pop),
        .Ptr   (rd_ptr)
    );

    // A word offered alongside Flush is discarded rather than stored.
    always_ff @(posedge Clock) begin
        if (push && !Flush) begin
            mem[wr_ptr] <= Data_In;
        end
    end

    assign Data_Out = mem[rd_ptr];

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= EMPTY;
            count_q <= '0;
        end else if (Flush) begin
            state_q <= EMPTY;
            count_q <= '0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (push) begin
                        state_q <= PARTIAL;
                        count_q <= count_q + CNT_W'(1);
                    end
                end
                PARTIAL: begin
                    if (push && !pop) begin
                        count_q <= count_q + CNT_W'(1);
                        if (count_q == CNT_LAST) begin
                            state_q <= FULL;
                        end
                    end else if (pop && !push) begin
                        count_q <= count_q - CNT_W'(1);
                        if (count_q == CNT_W'(1)) begin
                            state_q <= EMPTY;
                        end
                    end
                end
                FULL: begin
                    if (pop) begin
                        state_q <= PARTIAL;
                        count_q <= count_q - CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= EMPTY;
                    count_q <= '0;
                end
            endcase
        end
    end

    // A fresh overflow outranks a same-cycle clear so no event is lost.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            overflow_q <= 1'b0;
        end else if (ovf_set) begin
            overflow_q <= 1'b1;
        end else if (ErrorClear) begin
            overflow_q <= 1'b0;
        end
    end

    assign Count       = count_q;
    assign Overflow    = overflow_q;
    assign AlmostFull  = (int'(count_q) >= AF_LEVEL);
    assign AlmostEmpty = (int'(count_q) <= AE_LEVEL);

endmodule

// File: tb/tb_ring_queue.sv
// Directed bench for ring_queue at DEPTH=4, WIDTH=8, AF_LEVEL=3, AE_LEVEL=1.
module tb_ring_queue;

    logic       Clock = 1'b0;
    logic       Reset;
    logic       Flush;
    logic [7:0] Data_In;
    logic       InputValid;
    logic       InputReady;
    logic [7:0] Data_Out;
    logic       OutputValid;
    logic       ConsumerBusy;
    logic [2:0] Count;
    logic       AlmostFull;
    logic       AlmostEmpty;
    logic       Overflow;
    logic       ErrorClear;

    int n_assert = 0;
    int n_fail   = 0;

    ring_queue #(.DEPTH(4), .WIDTH(8), .AF_LEVEL(3), .AE_LEVEL(1)) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .Flush        (Flush),
        .Data_In      (Data_In),
        .InputValid   (InputValid),
        .InputReady   (InputReady),
        .Data_Out     (Data_Out),
        .OutputValid  (OutputValid),
        .ConsumerBusy (ConsumerBusy),
        .Count        (Count),
        .AlmostFull   (AlmostFull),
        .AlmostEmpty  (AlmostEmpty),
        .Overflow     (Overflow),
        .ErrorClear   (ErrorClear)
    );

    always #5 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic [7:0] d);
        InputValid = 1'b1;
        Data_In    = d;
        tick();
        InputValid = 1'b0;
    endtask

    logic [7:0] exp_head [6];

    initial begin
        Reset = 1'b1; Flush = 1'b0; Data_In = '0; InputValid = 1'b0;
        ConsumerBusy = 1'b1; ErrorClear = 1'b0;
        tick(); tick();
        Reset = 1'b0;

        chk("rst_count", 32'(Count), 0);
        chk("rst_ovalid", 32'(OutputValid), 0);
        chk("rst_iready", 32'(InputReady), 1);
        chk("rst_ae", 32'(AlmostEmpty), 1);
        chk("rst_af", 32'(AlmostFull), 0);
        chk("rst_ovf", 32'(Overflow), 0);

        // Single word: visible one cycle after its push edge
        push_word(8'hA1);
        chk("a1_ovalid", 32'(OutputValid), 1);
        chk("a1_data", 32'(Data_Out), 32'hA1);
        chk("a1_count", 32'(Count), 1);
        chk("a1_ae", 32'(AlmostEmpty), 1);
        ConsumerBusy = 1'b0;
        tick();
        ConsumerBusy = 1'b1;
        chk("a1_pop_count", 32'(Count), 0);
        chk("a1_pop_ovalid", 32'(OutputValid), 0);

        // Fill to full under back-pressure, then overflow
        for (int i = 1; i <= 4; i++) push_word(8'(i));
        chk("full_count", 32'(Count), 4);
        chk("full_iready", 32'(InputReady), 0);
        chk("full_af", 32'(AlmostFull), 1);
        chk("full_ae", 32'(AlmostEmpty), 0);
        chk("full_head", 32'(Data_Out), 32'h01);
        push_word(8'h05);
        chk("ovf_set", 32'(Overflow), 1);
        chk("ovf_count", 32'(Count), 4);
        chk("ovf_head", 32'(Data_Out), 32'h01);
        ErrorClear = 1'b1;
        tick();
        ErrorClear = 1'b0;
        chk("ovf_clear", 32'(Overflow), 0);

        // Simultaneous push/pop from full: first push (0x10) rejected
        exp_head[0] = 8'h01; exp_head[1] = 8'h02; exp_head[2] = 8'h03;
        exp_head[3] = 8'h04; exp_head[4] = 8'h11; exp_head[5] = 8'h12;
        ConsumerBusy = 1'b0;
        InputValid   = 1'b1;
        for (int i = 0; i < 6; i++) begin
            Data_In = 8'(8'h10 + i);
            #1;
            chk($sformatf("pp_head%0d", i), 32'(Data_Out), 32'(exp_head[i]));
            tick();
        end
        InputValid   = 1'b0;
        ConsumerBusy = 1'b1;
        chk("pp_count", 32'(Count), 3);
        chk("pp_ovf", 32'(Overflow), 1);
        ErrorClear = 1'b1;
        tick();
        ErrorClear = 1'b0;

        exp_head[0] = 8'h13; exp_head[1] = 8'h14; exp_head[2] = 8'h15;
        ConsumerBusy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("drain_head%0d", i), 32'(Data_Out), 32'(exp_head[i]));
            tick();
        end
        ConsumerBusy = 1'b1;
        chk("drain_count", 32'(Count), 0);
        chk("drain_ovalid", 32'(OutputValid), 0);

        // Flush wins over push and pop in the same cycle
        push_word(8'h20);
        push_word(8'h21);
        chk("two_count", 32'(Count), 2);
        chk("two_ae", 32'(AlmostEmpty), 0);
        chk("two_af", 32'(AlmostFull), 0);
        InputValid = 1'b1; Data_In = 8'h22; ConsumerBusy = 1'b0; Flush = 1'b1;
        tick();
        InputValid = 1'b0; ConsumerBusy = 1'b1; Flush = 1'b0;
        chk("flush_count", 32'(Count), 0);
        chk("flush_ovalid", 32'(OutputValid), 0);
        chk("flush_iready", 32'(InputReady), 1);
        push_word(8'h77);
        chk("post_flush_head", 32'(Data_Out), 32'h77);
        chk("post_flush_count", 32'(Count), 1);

        // Last pop to empty, then pop attempt while empty
        ConsumerBusy = 1'b0;
        tick();
        chk("to_empty_ovalid", 32'(OutputValid), 0);
        chk("to_empty_count", 32'(Count), 0);
        tick();
        ConsumerBusy = 1'b1;
        chk("empty_pop_count", 32'(Count), 0);
        chk("empty_pop_ovalid", 32'(OutputValid), 0);

        // Reset while full with overflow pending
        for (int i = 0; i < 5; i++) push_word(8'(8'h30 + i));
        chk("pre_rst_count", 32'(Count), 4);
        chk("pre_rst_ovf", 32'(Overflow), 1);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        chk("mid_rst_count", 32'(Count), 0);
        chk("mid_rst_ovf", 32'(Overflow), 0);
        chk("mid_rst_iready", 32'(InputReady), 1);
        chk("mid_rst_ovalid", 32'(OutputValid), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/ring_queue.md
Name: ring_queue

Overview:
- Parametrised circular-buffer FIFO for the mips32 datapath, e.g. between the fetch stage and the decode consumer.
- Provides a producer valid/ready handshake, consumer valid/busy handshake, first-word-fall-through output, occupancy count, programmable almost-full/almost-empty flags, synchronous flush and a sticky overflow flag.
- Data is stored in a memory array indexed by wrapping read/write pointers; entries are never shifted.

Parameters:
- DEPTH, 64, number of entries; any integer >= 2, not restricted to powers of two.
- WIDTH, 32, data word width in bits.
- AF_LEVEL, DEPTH-2, AlmostFull asserts when Count >= AF_LEVEL.
- AE_LEVEL, 2, AlmostEmpty asserts when Count <= AE_LEVEL.

Ports:
- Clock  in  1  rising-edge clock
- Reset  in  1  synchronous, active-high reset
- Flush  in  1  synchronous discard of all stored entries
- Data_In  in  WIDTH  producer data
- InputValid  in  1  producer offers Data_In this cycle
- InputReady  out  1  queue can accept a word (not full)
- Data_Out  out  WIDTH  head entry (FWFT)
- OutputValid  out  1  Data_Out holds a valid entry
- ConsumerBusy  in  1  consumer cannot take the head this cycle
- Count  out  $clog2(DEPTH+1)  current occupancy, 0..DEPTH
- AlmostFull  out  1  Count >= AF_LEVEL
- AlmostEmpty  out  1  Count <= AE_LEVEL
- Overflow  out  1  sticky: a write was attempted while full
- ErrorClear  in  1  clears Overflow

Behaviour:
- Reset: Clock and Reset are as decided (Reset synchronous, active-high; clock Clock).
  - Pointers = 0, Count = 0, state = EMPTY, Overflow = 0.
  - Outputs after reset: OutputValid = 0, InputReady = 1, AlmostEmpty = 1, AlmostFull = 0 (unless AF_LEVEL = 0).
  - Memory contents are not reset. Data_Out is don't-care while OutputValid = 0.
- State register: EMPTY (Count = 0), PARTIAL (0 < Count < DEPTH), FULL (Count = DEPTH). All flags decode from state and Count registers; no combinational path from inputs to InputReady or OutputValid.
- Push = InputValid & InputReady. Writes mem[wr_ptr] at the clock edge; wr_ptr advances.
- Pop = OutputValid & !ConsumerBusy. rd_ptr advances.
- Data_Out = mem[rd_ptr], combinational read of the registered array.
- Latency: a word pushed at edge N appears on Data_Out with OutputValid = 1 in the cycle after edge N.
- Pointer wrap: value DEPTH-1 increments to 0. Pointer width is $clog2(DEPTH); an explicit compare handles non-power-of-two DEPTH.
- Count update: Push only: +1. Pop only: -1. Push and Pop together: unchanged, both pointers advance.
- State transitions:
  - EMPTY -> PARTIAL on Push.
  - PARTIAL -> FULL on Push-only when Count = DEPTH-1.
  - PARTIAL -> EMPTY on Pop-only when Count = 1.
  - FULL -> PARTIAL on Pop.
  - DEPTH = 2 follows the same Count rules.
- Full: InputReady = 0. A Pop in the same cycle does not admit a push; the word is rejected.
  - InputValid while FULL sets Overflow at the next edge; data is dropped and Count is unchanged.
- Empty: Pop is impossible. ConsumerBusy is ignored.
- Flush (priority over Push/Pop in the same cycle): pointers = 0, Count = 0, state = EMPTY at the next edge. Overflow is unaffected.
- Overflow is sticky until ErrorClear or Reset. If ErrorClear and a new overflow event occur in the same cycle, the set wins.
- Reset mid-operation (any state) yields the reset values at the next edge. Reset has priority over Flush and ErrorClear.

Decomposition:
- Package ring_queue_pkg holds:
  - state typedef/localparams: EMPTY = 2'd0, PARTIAL = 2'd1, FULL = 2'd2.
  - width helper constants PTR_W = $clog2(DEPTH) and CNT_W = $clog2(DEPTH+1), computed from the module parameters.
- Sub-module ring_queue_ptr: wrapping pointer counter (params DEPTH; ports Clock, Reset, Clear, Inc, Ptr). Instantiated twice, once for read and once for write.

Test Plan (DEPTH = 4, WIDTH = 8, AF_LEVEL = 3, AE_LEVEL = 1):
- Reset, then push 0xA1 -> next cycle OutputValid = 1, Data_Out = 0xA1, Count = 1, AlmostEmpty = 1.
- Push 0x01..0x04 with ConsumerBusy = 1 -> Count = 4, InputReady = 0, AlmostFull = 1. A fifth InputValid with 0x05 -> Overflow = 1, Count stays 4, head still 0x01. ErrorClear -> Overflow = 0.
- Fill 4, then 6 cycles of simultaneous push (0x10..0x15) and pop -> pops while full reject the push. Output order follows wrap-around with no loss of accepted words; pointers wrap at 3 -> 0.
- Count = 2, assert Push, Pop and Flush in the same cycle -> Count = 0, OutputValid = 0. The pushed word is not stored. Next push of 0x77 appears as head.
- PARTIAL with Count = 1, single Pop -> state EMPTY, OutputValid = 0. Pop attempt while EMPTY -> Count remains 0, no underflow.
- Reset asserted while FULL and Overflow = 1 -> next cycle Count = 0, Overflow = 0, InputReady = 1, OutputValid = 0.
